motor_update_scheduler: RTL and testbench
=========================================

# motor_update_scheduler

Sequences setpoint and control-mode update frames from the Avalon register file into the serial coms engine, one motor at a time. Host writes mark per-motor updates pending. This block arbitrates among the motors round-robin and drives the single-cycle trigger and motor-select inputs of the coms engine. It then holds off until the engine reports frame completion or a timeout expires. It sits between the Avalon control logic and the coms instance, and replaces manual host sequencing of the trigger registers.

## Interface
- NUMBER_OF_MOTORS, 6, motors served; 1..255
- TIMEOUT_CYCLES, 50_000, cycles to wait for coms_done before abandoning a frame (1 ms at 50 MHz)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  scheduler may start new frames when high
- sp_dirty_set  in  NUMBER_OF_MOTORS  one-cycle pulse per bit; marks the motor's setpoint pending
- mode_dirty_set  in  NUMBER_OF_MOTORS  one-cycle pulse per bit; marks the motor's control mode pending
- coms_busy  in  1  coms engine is transmitting or receiving
- coms_done  in  1  one-cycle pulse when the triggered frame has completed
- trigger_setpoint_update  out  1  one-cycle start pulse to coms
- trigger_control_mode_update  out  1  one-cycle start pulse to coms
- motor_to_update  out  8  motor index for the current frame
- sp_pending  out  NUMBER_OF_MOTORS  pending setpoint bits, for readback
- mode_pending  out  NUMBER_OF_MOTORS  pending mode bits, for readback
- timeout_count  out  32  saturating count of abandoned frames

## Operation
- States: IDLE, SELECT, ISSUE, WAIT.
- **IDLE:** go to SELECT when enable=1 and (sp_pending|mode_pending)!=0.
- **SELECT:**
  - Stay while coms_busy=1.
  - Otherwise pick the first motor m, searching upward from the pointer ptr with wrap, whose sp or mode bit is pending.
  - Kind is MODE if mode_pending[m], else SP.
  - Register m into motor_to_update, then go to ISSUE.
- **ISSUE:**
  - Assert the trigger for the chosen kind for exactly one cycle.
  - Clear the chosen pending bit.
  - Go to WAIT.
- **WAIT:**
  - On coms_done, go to IDLE.
  - On TIMEOUT_CYCLES elapsed without coms_done: re-set the chosen pending bit, increment timeout_count (saturating at 2^32-1), go to IDLE.
- **Pointer:**
  - After a SP frame, ptr = (m+1) mod N.
  - After a MODE frame, ptr is unchanged if sp_pending[m] is still set; otherwise ptr = (m+1) mod N.
  - Effect: a motor's mode frame always precedes its setpoint frame.
  - A timed-out frame leaves ptr unchanged, so it is retried next.
- **Set/clear rules:**
  - A dirty_set pulse in any state sets its bit.
  - A set coinciding with the ISSUE clear of the same bit wins; the bit stays pending.
  - Repeated sets while pending coalesce into one frame.
- **enable low:** an in-flight frame completes normally. No new SELECT occurs. Pending bits keep accumulating.
- coms_done outside WAIT is ignored.
- **Reset:**
  - Applies from any state.
  - State=IDLE, ptr=0, all pending bits 0, both triggers 0, motor_to_update=0, timeout_count=0, timeout counter 0.
  - Reset during WAIT abandons the frame without counting it.

## Timing
- All outputs are registered.
- From a dirty_set pulse in cycle t, with state IDLE, enable=1 and coms_busy=0:
  - pending bit visible in t+1;
  - SELECT in t+2;
  - motor_to_update valid and trigger high in t+3.
- motor_to_update is stable from ISSUE until WAIT exits.
- Only one trigger is high in any cycle. No two triggers occur fewer than 3 cycles apart.
- Timeout counter starts at 0 in the first WAIT cycle. It fires on the cycle it reaches TIMEOUT_CYCLES-1.
- Minimum frame turnaround from coms_done to the next trigger is 3 cycles (IDLE, SELECT, ISSUE).

## Structure
- Package motor_update_scheduler_pkg holds:
  - state enum {IDLE, SELECT, ISSUE, WAIT};
  - kind enum {KIND_SP, KIND_MODE};
  - MOTOR_IDX_W = 8.
- One combinational sub-module, rr_pick. Inputs: request vector, ptr. Outputs: found flag, index of the first set bit at or after ptr, with wrap.
- Counters and pending registers live in the top module.

## Test plan
- Reset, then pulse sp_dirty_set=6'b000100 at cycle t, coms idle -> trigger_setpoint_update high only at t+3 with motor_to_update=2; sp_pending=0 afterward.
- Set mode and sp for motor 4, plus sp for motor 1, with ptr=0. Return coms_done 10 cycles after each trigger -> frame order is sp m1, mode m4, sp m4.
- Hold coms_busy=1 for 20 cycles with a frame pending -> no trigger until 1 cycle after busy falls, then trigger in the following cycle.
- Use TIMEOUT_CYCLES=16 and never pulse coms_done -> timeout_count increments every frame, the same motor is retried, and sp_pending bit is re-set after each timeout.
- Pulse sp_dirty_set[3] in the ISSUE cycle of motor 3's SP frame -> bit remains 1 and a second SP frame for motor 3 is issued.
- Assert reset in WAIT, then pulse coms_done -> no trigger, all pending 0, timeout_count 0.

Source files
------------

// File: rtl/motor_update_scheduler_pkg.sv
// Shared types for the motor update scheduler: FSM states, frame kinds, index width.
// Pure declarations, no logic.
// Imported by the top module and its round-robin picker.
package motor_update_scheduler_pkg;

    localparam int MOTOR_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        KIND_SP,
        KIND_MODE
    } kind_t;

endpackage

// File: rtl/motor_update_scheduler_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping to bit 0.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module motor_update_scheduler_rr_pick
    import motor_update_scheduler_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]             req_i,
    input  logic [MOTOR_IDX_W-1:0]   ptr_i,
    output logic                     found_o,
    output logic [MOTOR_IDX_W-1:0]   idx_o
);

    logic                   found_hi;
    logic [MOTOR_IDX_W-1:0] idx_hi;
    logic                   found_any;
    logic [MOTOR_IDX_W-1:0] idx_any;

    // Scan downward so the lowest qualifying index is the one left standing;
    // the "at or above ptr" hit takes priority over the wrapped hit.
    always_comb begin
        found_hi  = 1'b0;
        idx_hi    = '0;
        found_any = 1'b0;
        idx_any   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                found_any = 1'b1;
                idx_any   = MOTOR_IDX_W'(k);
                if (MOTOR_IDX_W'(k) >= ptr_i) begin
                    found_hi = 1'b1;
                    idx_hi   = MOTOR_IDX_W'(k);
                end
            end
        end
        found_o = found_any;
        idx_o   = found_hi ? idx_hi : idx_any;
    end

endmodule

// File: rtl/motor_update_scheduler.sv
// Schedules per-motor setpoint / control-mode frames into the coms engine, round-robin.
// Dirty pulse to trigger is 3 cycles when idle; all outputs registered.
// Holds in SELECT while coms_busy, and in WAIT until coms_done or timeout.
module motor_update_scheduler
    import motor_update_scheduler_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int TIMEOUT_CYCLES   = 50_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUMBER_OF_MOTORS-1:0]   sp_dirty_set,
    input  logic [NUMBER_OF_MOTORS-1:0]   mode_dirty_set,
    input  logic                          coms_busy,
    input  logic                          coms_done,
    output logic                          trigger_setpoint_update,
    output logic                          trigger_control_mode_update,
    output logic [7:0]                    motor_to_update,
    output logic [NUMBER_OF_MOTORS-1:0]   sp_pending,
    output logic [NUMBER_OF_MOTORS-1:0]   mode_pending,
    output logic [31:0]                   timeout_count
);

    localparam int N = NUMBER_OF_MOTORS;

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;
    logic [MOTOR_IDX_W-1:0] ptr_q, ptr_d;
    logic [MOTOR_IDX_W-1:0] motor_q, motor_d;
    logic                   trig_sp_q, trig_sp_d;
    logic                   trig_mode_q, trig_mode_d;
    logic [N-1:0]           sp_pend_q, sp_pend_d;
    logic [N-1:0]           mode_pend_q, mode_pend_d;
    logic [31:0]            tmo_cnt_q, tmo_cnt_d;
    logic [31:0]            tmo_total_q, tmo_total_d;

    logic [N-1:0]           req;
    logic                   pick_found;
    logic [MOTOR_IDX_W-1:0] pick_idx;
    logic [N-1:0]           pick_mask;
    logic [N-1:0]           sel_mask;
    logic [N-1:0]           sp_clr, mode_clr, sp_reset, mode_reset;
    logic [MOTOR_IDX_W-1:0] ptr_next;

    assign req = sp_pend_q | mode_pend_q;

    motor_update_scheduler_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // One-hot masks for the candidate and the latched motor, avoiding
    // variable-width bit selects into the pending vectors.
    always_comb begin
        pick_mask = '0;
        sel_mask  = '0;
        for (int k = 0; k < N; k++) begin
            pick_mask[k] = (pick_idx == MOTOR_IDX_W'(k));
            sel_mask[k]  = (motor_q == MOTOR_IDX_W'(k));
        end
    end

    assign ptr_next = (motor_q == MOTOR_IDX_W'(N - 1)) ? '0 : motor_q + 1'b1;

    // Next-state, trigger generation, pending clear/re-set and counters.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        ptr_d       = ptr_q;
        motor_d     = motor_q;
        trig_sp_d   = 1'b0;
        trig_mode_d = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_total_d = tmo_total_q;
        sp_clr      = '0;
        mode_clr    = '0;
        sp_reset    = '0;
        mode_reset  = '0;

        case (state_q)
            IDLE: begin
                if (enable && (req != '0)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!coms_busy) begin
                    if (pick_found) begin
                        motor_d = pick_idx;
                        if ((mode_pend_q & pick_mask) != '0) begin
                            kind_d      = KIND_MODE;
                            trig_mode_d = 1'b1;
                        end else begin
                            kind_d    = KIND_SP;
                            trig_sp_d = 1'b1;
                        end
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ISSUE: begin
                if (kind_q == KIND_MODE) begin
                    mode_clr = sel_mask;
                end else begin
                    sp_clr = sel_mask;
                end
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (coms_done) begin
                    // A mode frame keeps the pointer on its motor while that
                    // motor's setpoint is still owed, so mode precedes setpoint.
                    if (kind_q == KIND_SP || (sp_pend_q & sel_mask) == '0) begin
                        ptr_d = ptr_next;
                    end
                    state_d = IDLE;
                end else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    if (kind_q == KIND_MODE) begin
                        mode_reset = sel_mask;
                    end else begin
                        sp_reset = sel_mask;
                    end
                    if (tmo_total_q != '1) begin
                        tmo_total_d = tmo_total_q + 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sets are applied after the clear so a coincident set keeps the bit.
        sp_pend_d   = (sp_pend_q & ~sp_clr) | sp_dirty_set | sp_reset;
        mode_pend_d = (mode_pend_q & ~mode_clr) | mode_dirty_set | mode_reset;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            kind_q      <= KIND_SP;
            ptr_q       <= '0;
            motor_q     <= '0;
            trig_sp_q   <= 1'b0;
            trig_mode_q <= 1'b0;
            sp_pend_q   <= '0;
            mode_pend_q <= '0;
            tmo_cnt_q   <= '0;
            tmo_total_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            ptr_q       <= ptr_d;
            motor_q     <= motor_d;
            trig_sp_q   <= trig_sp_d;
            trig_mode_q <= trig_mode_d;
            sp_pend_q   <= sp_pend_d;
            mode_pend_q <= mode_pend_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_total_q <= tmo_total_d;
        end
    end

    assign trigger_setpoint_update     = trig_sp_q;
    assign trigger_control_mode_update = trig_mode_q;
    assign motor_to_update             = motor_q;
    assign sp_pending                  = sp_pend_q;
    assign mode_pending                = mode_pend_q;
    assign timeout_count               = tmo_total_q;

endmodule

// File: tb/tb_motor_update_scheduler.sv
// Directed bench for motor_update_scheduler with a frame scoreboard.
// Expected frames are queued as stimulus is driven; a monitor pops on each trigger.
// Cycle-exact checks cover latency, busy hold-off, timeout and reset behaviour.
module tb_motor_update_scheduler;

    localparam int N   = 6;
    localparam int TMO = 16;

    typedef struct {
        logic       kind;   // 1 = control mode, 0 = setpoint
        logic [7:0] motor;
    } frame_t;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [N-1:0] sp_dirty_set;
    logic [N-1:0] mode_dirty_set;
    logic         coms_busy;
    logic         coms_done;
    logic         trig_sp;
    logic         trig_mode;
    logic [7:0]   motor;
    logic [N-1:0] sp_pending;
    logic [N-1:0] mode_pending;
    logic [31:0]  timeout_count;

    int tests = 0;
    int fails = 0;
    frame_t exp_q[$];

    motor_update_scheduler #(
        .NUMBER_OF_MOTORS (N),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .enable                      (enable),
        .sp_dirty_set                (sp_dirty_set),
        .mode_dirty_set              (mode_dirty_set),
        .coms_busy                   (coms_busy),
        .coms_done                   (coms_done),
        .trigger_setpoint_update     (trig_sp),
        .trigger_control_mode_update (trig_mode),
        .motor_to_update             (motor),
        .sp_pending                  (sp_pending),
        .mode_pending                (mode_pending),
        .timeout_count               (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sp(input logic [N-1:0] m);
        sp_dirty_set = m;
        tick();
        sp_dirty_set = '0;
    endtask

    task automatic pulse_mode(input logic [N-1:0] m);
        mode_dirty_set = m;
        tick();
        mode_dirty_set = '0;
    endtask

    task automatic pulse_done();
        coms_done = 1'b1;
        tick();
        coms_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic push_frame(input logic kind, input logic [7:0] m);
        frame_t f;
        f.kind  = kind;
        f.motor = m;
        exp_q.push_back(f);
    endtask

    // Leaves the caller in the ISSUE cycle of the next frame.
    task automatic wait_trigger(input int max_cyc);
        int n = 0;
        while (!(trig_sp || trig_mode) && n < max_cyc) begin
            tick();
            n++;
        end
        check("trigger_arrives", 32'(trig_sp || trig_mode), 32'd1);
    endtask

    task automatic finish_frame();
        repeat (3) tick();
        pulse_done();
    endtask

    // Scoreboard: every trigger must match the oldest expected frame.
    always @(negedge clk) begin
        if (trig_sp || trig_mode) begin
            check("single_trigger", 32'(trig_sp && trig_mode), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_trigger", {24'd0, motor}, 32'hFFFF_FFFF);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_kind", 32'(trig_mode), 32'(f.kind));
                check("frame_motor", {24'd0, motor}, {24'd0, f.motor});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset          = 1'b1;
        enable         = 1'b1;
        sp_dirty_set   = '0;
        mode_dirty_set = '0;
        coms_busy      = 1'b0;
        coms_done      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_trig_sp", 32'(trig_sp), 32'd0);
        check("rst_trig_mode", 32'(trig_mode), 32'd0);
        check("rst_motor", {24'd0, motor}, 32'd0);
        check("rst_sp_pending", 32'(sp_pending), 32'd0);
        check("rst_mode_pending", 32'(mode_pending), 32'd0);
        check("rst_timeout_count", timeout_count, 32'd0);

        // Latency: pulse in cycle t, trigger exactly in t+3
        sp_dirty_set = 6'b000100;
        tick();
        sp_dirty_set = '0;
        check("lat_pending_t1", 32'(sp_pending), 32'h4);
        check("lat_no_trig_t1", 32'(trig_sp), 32'd0);
        push_frame(1'b0, 8'd2);
        tick();
        check("lat_no_trig_t2", 32'(trig_sp), 32'd0);
        tick();
        check("lat_trig_t3", 32'(trig_sp), 32'd1);
        check("lat_motor_t3", {24'd0, motor}, 32'd2);
        tick();
        check("lat_trig_low_t4", 32'(trig_sp), 32'd0);
        check("lat_pending_cleared", 32'(sp_pending), 32'd0);
        pulse_done();

        // Ordering with ptr=0: sp m1, mode m4, sp m4
        do_reset();
        sp_dirty_set   = 6'b010010;
        mode_dirty_set = 6'b010000;
        tick();
        sp_dirty_set   = '0;
        mode_dirty_set = '0;
        push_frame(1'b0, 8'd1);
        push_frame(1'b1, 8'd4);
        push_frame(1'b0, 8'd4);
        for (int f = 0; f < 3; f++) begin
            wait_trigger(20);
            repeat (10) tick();
            pulse_done();
        end
        check("order_sp_drained", 32'(sp_pending), 32'd0);
        check("order_mode_drained", 32'(mode_pending), 32'd0);

        // Busy hold-off: trigger only one cycle after busy falls
        coms_busy = 1'b1;
        pulse_sp(6'b100000);
        push_frame(1'b0, 8'd5);
        cnt = 0;
        repeat (20) begin
            tick();
            if (trig_sp || trig_mode) cnt++;
        end
        check("busy_no_trigger", cnt, 32'd0);
        coms_busy = 1'b0;
        check("busy_fall_cycle", 32'(trig_sp), 32'd0);
        tick();
        check("busy_trigger_next", 32'(trig_sp), 32'd1);
        finish_frame();

        // Timeout: ptr has wrapped to 0; motor 2 retried, not 4
        pulse_sp(6'b010100);
        for (int r = 0; r < 2; r++) begin
            push_frame(1'b0, 8'd2);
            wait_trigger(20);
            tick();
            check("tmo_bit_cleared", 32'(sp_pending), 32'h10);
            repeat (TMO - 1) tick();
            check("tmo_not_yet", timeout_count, 32'(r));
            tick();
            check("tmo_count", timeout_count, 32'(r + 1));
            check("tmo_bit_reset", 32'(sp_pending), 32'h14);
        end
        push_frame(1'b0, 8'd2);
        wait_trigger(20);
        finish_frame();
        push_frame(1'b0, 8'd4);
        wait_trigger(20);
        finish_frame();
        check("tmo_total_kept", timeout_count, 32'd2);

        // Set coinciding with the ISSUE clear wins
        pulse_sp(6'b001000);
        push_frame(1'b0, 8'd3);
        wait_trigger(20);
        sp_dirty_set = 6'b001000;
        tick();
        sp_dirty_set = '0;
        check("coincide_bit_kept", 32'(sp_pending), 32'h08);
        push_frame(1'b0, 8'd3);
        finish_frame();
        wait_trigger(20);
        finish_frame();
        check("coincide_drained", 32'(sp_pending), 32'd0);

        // enable low holds frames; repeated sets coalesce into one
        enable = 1'b0;
        pulse_mode(6'b000010);
        pulse_mode(6'b000010);
        repeat (10) tick();
        check("disabled_mode_pending", 32'(mode_pending), 32'h02);
        push_frame(1'b1, 8'd1);
        enable = 1'b1;
        wait_trigger(20);
        finish_frame();
        repeat (10) tick();
        check("coalesce_drained", 32'(mode_pending), 32'd0);

        // Reset during WAIT abandons the frame
        sp_dirty_set   = 6'b000001;
        mode_dirty_set = 6'b100000;
        tick();
        sp_dirty_set   = '0;
        mode_dirty_set = '0;
        push_frame(1'b1, 8'd5);
        wait_trigger(20);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_done();
        repeat (10) tick();
        check("wrst_sp_pending", 32'(sp_pending), 32'd0);
        check("wrst_mode_pending", 32'(mode_pending), 32'd0);
        check("wrst_timeout_count", timeout_count, 32'd0);
        check("wrst_motor", {24'd0, motor}, 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
